// File: rtl/jump_pkg.sv
// Shared types and widths for the jump request controller.
package jump_pkg;

  typedef enum logic [1:0] {
    GROUND = 2'd0,
    LAUNCH = 2'd1,
    AIR    = 2'd2
  } jump_state_t;

  localparam int HEIGHT_W = 10;
  localparam int COUNT_W  = 8;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus counter debouncer; emits a one-cycle pulse on each accepted press.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_level,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          sync_a;
  logic          btn_sync;
  logic          level_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_a    <= 1'b0;
      btn_sync  <= 1'b0;
      level_q   <= 1'b0;
      btn_level <= 1'b0;
      cnt       <= '0;
    end else begin
      sync_a   <= btn_raw;
      btn_sync <= sync_a;
      level_q  <= btn_level;
      // Any cycle where the synchronized input agrees with the level restarts the count.
      if (btn_sync != btn_level) begin
        if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          btn_level <= ~btn_level;
          cnt       <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign press = btn_level & ~level_q;

endmodule

// File: rtl/jump_request_ctrl.sv
// Turns debounced button presses into single-cycle jump requests, with a mid-air press buffer.
module jump_request_ctrl
  import jump_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int BUFFER_FRAMES   = 8,
  parameter int LAUNCH_TIMEOUT  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                btn_raw,
  input  logic                frame_tick,
  input  logic [HEIGHT_W-1:0] height,
  input  logic                game_active,
  output logic                jump_en,
  output logic                btn_level,
  output logic                airborne,
  output logic                buf_pending,
  output logic [COUNT_W-1:0]  jump_count,
  output logic [1:0]          fsm_state
);

  localparam int BW = $clog2(BUFFER_FRAMES + 1);
  localparam int LW = $clog2(LAUNCH_TIMEOUT + 1);

  jump_state_t   state;
  logic          press;
  logic          press_ok;
  logic          game_active_q;
  logic [BW-1:0] buf_timer;
  logic [LW-1:0] launch_cnt;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk      (clk),
    .reset    (reset),
    .btn_raw  (btn_raw),
    .btn_level(btn_level),
    .press    (press)
  );

  // A press landing on the first active cycle after a pause is dropped.
  assign press_ok  = press & game_active & game_active_q;
  assign airborne  = (state != GROUND);
  assign fsm_state = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= GROUND;
      jump_en       <= 1'b0;
      buf_pending   <= 1'b0;
      buf_timer     <= '0;
      launch_cnt    <= '0;
      jump_count    <= '0;
      game_active_q <= 1'b0;
    end else begin
      jump_en       <= 1'b0;
      game_active_q <= game_active;
      if (jump_en) jump_count <= jump_count + 1'b1;

      if (!game_active) begin
        state       <= GROUND;
        buf_pending <= 1'b0;
        buf_timer   <= '0;
        launch_cnt  <= '0;
      end else begin
        case (state)
          GROUND: begin
            // Consuming a buffered press also beats a same-cycle expiry tick.
            if (press_ok || buf_pending) begin
              jump_en     <= 1'b1;
              buf_pending <= 1'b0;
              buf_timer   <= '0;
              launch_cnt  <= '0;
              state       <= LAUNCH;
            end
          end
          LAUNCH: begin
            if (height != '0) begin
              state <= AIR;
            end else if (launch_cnt == LW'(LAUNCH_TIMEOUT - 1)) begin
              state <= GROUND;
            end else begin
              launch_cnt <= launch_cnt + 1'b1;
            end
          end
          AIR: begin
            if (height == '0) state <= GROUND;
          end
          default: state <= GROUND;
        endcase

        // Presses while off the ground arm the buffer; a reload masks a coincident tick.
        if (state != GROUND) begin
          if (press_ok) begin
            buf_pending <= 1'b1;
            buf_timer   <= BW'(BUFFER_FRAMES);
          end else if (frame_tick && buf_pending) begin
            if (buf_timer == BW'(1)) begin
              buf_pending <= 1'b0;
              buf_timer   <= '0;
            end else begin
              buf_timer <= buf_timer - 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_jump_request_ctrl.sv
// Directed bench for jump_request_ctrl with short debounce and buffer settings.
module tb_jump_request_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_raw;
  logic       frame_tick;
  logic [9:0] height;
  logic       game_active;
  logic       jump_en;
  logic       btn_level;
  logic       airborne;
  logic       buf_pending;
  logic [7:0] jump_count;
  logic [1:0] fsm_state;

  int n_cmp = 0;
  int n_err = 0;

  jump_request_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .BUFFER_FRAMES  (3),
    .LAUNCH_TIMEOUT (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_raw    (btn_raw),
    .frame_tick (frame_tick),
    .height     (height),
    .game_active(game_active),
    .jump_en    (jump_en),
    .btn_level  (btn_level),
    .airborne   (airborne),
    .buf_pending(buf_pending),
    .jump_count (jump_count),
    .fsm_state  (fsm_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic release_btn();
    btn_raw = 1'b0;
    repeat (8) tick();
  endtask

  task automatic pulse_frame();
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0; btn_raw = 1'b0; frame_tick = 1'b0; height = '0; game_active = 1'b1;
    repeat (2) tick();
    n_cmp++;
    if ({jump_en, btn_level, airborne, buf_pending, jump_count, fsm_state} !== 13'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b required 0", {jump_en, btn_level, airborne, buf_pending, jump_count, fsm_state});
    end
    reset = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_bounce();
    int bad_level = 0;
    int bad_jump = 0;
    for (int i = 0; i < 28; i++) begin
      btn_raw = (i < 20) ? ((i / 2) % 2 == 1) : 1'b0;
      tick();
      if (btn_level !== 1'b0) bad_level++;
      if (jump_en !== 1'b0) bad_jump++;
    end
    n_cmp++;
    if (bad_level != 0) begin n_err++; $display("FAIL bounce_level: %0d cycles high, required 0", bad_level); end
    n_cmp++;
    if (bad_jump != 0) begin n_err++; $display("FAIL bounce_jump: %0d pulses, required 0", bad_jump); end
  endtask

  task automatic test_clean_press();
    btn_raw = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      n_cmp++;
      if (jump_en !== (c == 7)) begin
        n_err++; $display("FAIL clean_jump_en c%0d: got %b required %b", c, jump_en, (c == 7));
      end
      if (c == 7) height = 10'd7;
      if (c >= 8) begin
        n_cmp++;
        if (airborne !== 1'b1) begin n_err++; $display("FAIL clean_airborne c%0d: got %b required 1", c, airborne); end
      end
    end
    n_cmp++;
    if (jump_count !== 8'd1) begin n_err++; $display("FAIL clean_count: got %0d required 1", jump_count); end
    n_cmp++;
    if (fsm_state !== 2'd2) begin n_err++; $display("FAIL clean_state: got %0d required 2", fsm_state); end
  endtask

  task automatic test_buffered();
    height = 10'd56;
    release_btn();
    btn_raw = 1'b1;
    repeat (6) tick();
    n_cmp++;
    if (buf_pending !== 1'b0) begin n_err++; $display("FAIL buf_early: got %b required 0", buf_pending); end
    tick();
    n_cmp++;
    if (buf_pending !== 1'b1) begin n_err++; $display("FAIL buf_set: got %b required 1", buf_pending); end
    pulse_frame();
    pulse_frame();
    n_cmp++;
    if (buf_pending !== 1'b1) begin n_err++; $display("FAIL buf_after_2ticks: got %b required 1", buf_pending); end
    height = '0;
    tick();
    n_cmp++;
    if ({jump_en, airborne, buf_pending} !== 3'b001) begin
      n_err++; $display("FAIL buf_landing: got jump/air/pend %b required 001", {jump_en, airborne, buf_pending});
    end
    tick();
    n_cmp++;
    if ({jump_en, airborne, buf_pending} !== 3'b110) begin
      n_err++; $display("FAIL buf_fire: got jump/air/pend %b required 110", {jump_en, airborne, buf_pending});
    end
    height = 10'd7;
    tick();
    n_cmp++;
    if ({jump_en, jump_count} !== {1'b0, 8'd2}) begin
      n_err++; $display("FAIL buf_count: got jump %b count %0d required 0/2", jump_en, jump_count);
    end
  endtask

  task automatic test_expiry();
    int bad_jump = 0;
    release_btn();
    btn_raw = 1'b1;
    repeat (7) tick();
    n_cmp++;
    if (buf_pending !== 1'b1) begin n_err++; $display("FAIL exp_set: got %b required 1", buf_pending); end
    pulse_frame();
    pulse_frame();
    n_cmp++;
    if (buf_pending !== 1'b1) begin n_err++; $display("FAIL exp_after_2ticks: got %b required 1", buf_pending); end
    pulse_frame();
    n_cmp++;
    if (buf_pending !== 1'b0) begin n_err++; $display("FAIL exp_cleared: got %b required 0", buf_pending); end
    height = '0;
    repeat (5) begin
      tick();
      if (jump_en !== 1'b0) bad_jump++;
    end
    n_cmp++;
    if (bad_jump != 0) begin n_err++; $display("FAIL exp_no_jump: %0d pulses, required 0", bad_jump); end
    n_cmp++;
    if ({airborne, jump_count} !== {1'b0, 8'd2}) begin
      n_err++; $display("FAIL exp_final: got air %b count %0d required 0/2", airborne, jump_count);
    end
  endtask

  task automatic test_launch_timeout();
    release_btn();
    btn_raw = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      tick();
      n_cmp++;
      if (jump_en !== (c == 7)) begin
        n_err++; $display("FAIL lto_jump_en c%0d: got %b required %b", c, jump_en, (c == 7));
      end
      if (c == 10 || c == 11) begin
        n_cmp++;
        if (airborne !== (c == 10)) begin
          n_err++; $display("FAIL lto_airborne c%0d: got %b required %b", c, airborne, (c == 10));
        end
      end
    end
    n_cmp++;
    if ({fsm_state, jump_count} !== {2'd0, 8'd3}) begin
      n_err++; $display("FAIL lto_final: got state %0d count %0d required 0/3", fsm_state, jump_count);
    end
  endtask

  task automatic test_inactive();
    int bad_jump = 0;
    game_active = 1'b0;
    release_btn();
    btn_raw = 1'b1;
    repeat (10) begin
      tick();
      if (jump_en !== 1'b0) bad_jump++;
    end
    n_cmp++;
    if (btn_level !== 1'b1) begin n_err++; $display("FAIL inact_level: got %b required 1", btn_level); end
    game_active = 1'b1;
    repeat (4) begin
      tick();
      if (jump_en !== 1'b0) bad_jump++;
    end
    // Press arrives exactly as gameplay resumes.
    game_active = 1'b0;
    release_btn();
    btn_raw = 1'b1;
    repeat (6) tick();
    game_active = 1'b1;
    repeat (6) begin
      tick();
      if (jump_en !== 1'b0 || buf_pending !== 1'b0) bad_jump++;
    end
    n_cmp++;
    if (bad_jump != 0) begin n_err++; $display("FAIL inact_no_jump: %0d bad cycles, required 0", bad_jump); end
    n_cmp++;
    if (jump_count !== 8'd3) begin n_err++; $display("FAIL inact_count: got %0d required 3", jump_count); end
  endtask

  task automatic test_async_reset();
    release_btn();
    btn_raw = 1'b1;
    repeat (7) tick();
    height = 10'd7;
    tick();
    release_btn();
    btn_raw = 1'b1;
    repeat (7) tick();
    n_cmp++;
    if ({airborne, buf_pending, jump_count} !== {1'b1, 1'b1, 8'd4}) begin
      n_err++; $display("FAIL rst_pre: got air %b pend %b count %0d required 1/1/4", airborne, buf_pending, jump_count);
    end
    #2;
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({jump_en, btn_level, airborne, buf_pending, jump_count, fsm_state} !== 13'd0) begin
      n_err++;
      $display("FAIL rst_async: got %b required 0", {jump_en, btn_level, airborne, buf_pending, jump_count, fsm_state});
    end
    tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_clean_press();
    test_buffered();
    test_expiry();
    test_launch_timeout();
    test_inactive();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/jump_request_ctrl.md
# jump_request_ctrl

Generates the `en` request consumed by the player jump block from the raw jump button. It synchronizes and debounces the button and issues exactly one single-cycle jump request per accepted press. It tracks the player's airborne state from the jump block's height output and buffers a press made in mid-air so it fires on landing. It sits between the board button input and the jump block in the game top level.

## Interface
- `DEBOUNCE_CYCLES`, 250000: consecutive stable cycles required before the debounced level changes (10 ms at 25 MHz).
- `BUFFER_FRAMES`, 8: number of `frame_tick` strobes a mid-air press stays pending.
- `LAUNCH_TIMEOUT`, 4: cycles to wait in LAUNCH for `height` to leave 0.
- `clk` in 1: system clock, all logic on rising edge.
- `reset` in 1: asynchronous, active-low (asserted at 0); all state and outputs to reset values.
- `btn_raw` in 1: asynchronous button, active-high.
- `frame_tick` in 1: one-cycle strobe, once per video frame.
- `height` in 10: player vertical offset from the jump block; 0 means grounded.
- `game_active` in 1: gameplay enabled.
- `jump_en` out 1: registered one-cycle jump request to the jump block.
- `btn_level` out 1: debounced button level.
- `airborne` out 1: high in LAUNCH or AIR.
- `buf_pending` out 1: a buffered press is waiting.
- `jump_count` out 8: number of `jump_en` pulses issued, wraps 255→0.

## Operation
- Reset values: all outputs 0, state GROUND, debounce counter 0, buffer timer 0, synchronizer flops 0.
- Synchronizer: 2 flops on `btn_raw`, giving `btn_sync`.
- Debounce counter:
  - If `btn_sync` != `btn_level`, the counter increments; otherwise it clears.
  - When the counter reaches `DEBOUNCE_CYCLES`-1 with the mismatch still present, `btn_level` toggles and the counter clears.
  - Counter width is clog2(`DEBOUNCE_CYCLES`).
- `press` is a combinational pulse on the rising edge of `btn_level`, high for one cycle. The release edge is ignored.
- FSM states and transitions:
  - GROUND: on `press` or `buf_pending`, set `jump_en`=1 next cycle, clear the buffer, go to LAUNCH.
  - LAUNCH: if `height` != 0, go to AIR. Otherwise, after `LAUNCH_TIMEOUT` cycles in LAUNCH, go to GROUND; the jump is lost and not retried.
  - AIR: when `height` == 0, go to GROUND.
- Buffer:
  - A `press` in LAUNCH or AIR sets `buf_pending`=1 and loads the timer with `BUFFER_FRAMES`.
  - A repeat press reloads the timer.
  - Each `frame_tick` decrements the timer. On the tick where the timer is 1, `buf_pending` clears.
- `jump_count` increments on the cycle `jump_en` is high.
- `game_active`=0:
  - Forces GROUND, clears the buffer and timer, and holds `jump_en` at 0.
  - The debouncer keeps running.
  - Presses are discarded. A press that coincides with `game_active` rising is also discarded.

## Timing
- Latency from `btn_raw` edge to `jump_en`:
  - 2 cycles of synchronization.
  - `DEBOUNCE_CYCLES` cycles to `btn_level`.
  - `jump_en` one cycle after `press`. The total is 3+`DEBOUNCE_CYCLES`.
- `jump_en` is never high on two consecutive cycles. The minimum spacing between pulses is the LAUNCH→AIR→GROUND path.
- Simultaneous events:
  - A press in the same cycle as AIR→GROUND (landing) is buffered. It fires on the next cycle from GROUND, 2 cycles after landing.
  - A landing consume and a `frame_tick` expiry in the same cycle: consume wins and `jump_en` fires.
  - A press together with a `frame_tick` in AIR: the timer loads `BUFFER_FRAMES` and the tick is ignored.
- Reset mid-operation: immediate asynchronous return to reset values. A `jump_en` in flight is dropped.

## Structure
- Package `jump_pkg`:
  - `jump_state_t` enum {GROUND, LAUNCH, AIR}.
  - `HEIGHT_W` = 10.
  - `COUNT_W` = 8.
- Sub-module `btn_debounce`: synchronizer, debounce counter, `btn_level`, `press`. It is parameterized by `DEBOUNCE_CYCLES`.
- The top level holds the FSM, buffer timer, and `jump_count`.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `BUFFER_FRAMES`=3, `LAUNCH_TIMEOUT`=4.
- Bounce rejection: `btn_raw` toggles every 2 cycles for 20 cycles, then holds 0 → `btn_level` stays 0, no `jump_en`.
- Clean press:
  - Stimulus: `btn_raw` rises at cycle 0 and holds; `height` model rises to 7 the cycle after `jump_en`.
  - Response: `jump_en` pulses at cycle 7 only, `airborne`=1 from cycle 8, `jump_count`=1.
- Buffered jump:
  - Stimulus: press while `height`=56, then 2 `frame_tick`s, then `height`=0.
  - Response: `buf_pending`=1 until consumed, `jump_en` pulses 2 cycles after landing, `jump_count`=2.
- Buffer expiry:
  - Stimulus: press in AIR, then 3 `frame_tick`s before landing.
  - Response: `buf_pending` clears on the 3rd tick, no `jump_en` after landing.
- Launch timeout: press with `height` held at 0 → one `jump_en`, back in GROUND after 4 cycles, `airborne`=0, no retry.
- Inactive and reset:
  - `game_active`=0 during a press → no `jump_en`.
  - `reset`=0 in AIR with `buf_pending`=1 → all outputs 0 immediately, `jump_count`=0.
